// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Define IF_IRQ_EN to build in interrupt entry; without it irq is ignored and if_id_irq is 0.
module if_stage #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redir_valid,
    input  logic [31:0] i_redir_target,
    input  logic        i_exc,
    input  logic        i_irq,
    output logic [31:0] o_inst_addr,
    input  logic [31:0] i_inst_data,
    output logic [31:0] o_if_id_inst,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_if_id_irq
);

    typedef enum logic [2:0] {
        ActSeq,
        ActStall,
        ActIrq,
        ActRedir,
        ActExc
    } action_e;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_irq;

    action_e     w_action;
    logic        w_irq_take;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_next;
    logic        w_slot_load;
    logic [31:0] w_inst_next;
    logic [31:0] w_pc4_next;
    logic        w_valid_next;
    logic        w_irq_next;

    // Bit 31 is the kernel-mode flag, so the increment never carries into it.
    assign w_pc_seq = {r_pc[31], r_pc[30:0] + 31'd4};

`ifdef IF_IRQ_EN
    assign w_irq_take = i_irq & ~r_pc[31] & ~i_stall & ~i_exc & ~i_redir_valid;
`else
    logic w_irq_unused;
    assign w_irq_take   = 1'b0;
    assign w_irq_unused = i_irq ^ (^IRQ_VEC);
`endif

    always_comb begin
        w_action = ActSeq;
        if (i_exc) begin
            w_action = ActExc;
        end else if (i_redir_valid) begin
            w_action = ActRedir;
        end else if (w_irq_take) begin
            w_action = ActIrq;
        end else if (i_stall) begin
            w_action = ActStall;
        end
    end

    always_comb begin
        w_pc_next    = w_pc_seq;
        w_slot_load  = 1'b1;
        w_inst_next  = i_inst_data;
        w_pc4_next   = w_pc_seq;
        w_valid_next = 1'b1;
        w_irq_next   = 1'b0;
        unique case (w_action)
            ActExc: begin
                w_pc_next    = EXC_VEC;
                w_inst_next  = '0;
                w_pc4_next   = '0;
                w_valid_next = 1'b0;
            end
            ActRedir: begin
                // A redirect may leave kernel mode but never enter it.
                w_pc_next    = {r_pc[31] & i_redir_target[31], i_redir_target[30:0]};
                w_inst_next  = '0;
                w_pc4_next   = '0;
                w_valid_next = 1'b0;
            end
            ActIrq: begin
`ifdef IF_IRQ_EN
                w_pc_next    = IRQ_VEC;
`endif
                // pc4 carries the return address; the interrupted instruction is replayed.
                w_inst_next  = '0;
                w_valid_next = 1'b0;
                w_irq_next   = 1'b1;
            end
            ActStall: begin
                w_pc_next   = r_pc;
                w_slot_load = 1'b0;
            end
            default: begin
                w_pc_next = w_pc_seq;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_inst  <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
            r_irq   <= 1'b0;
        end else if (w_slot_load) begin
            r_inst  <= w_inst_next;
            r_pc4   <= w_pc4_next;
            r_valid <= w_valid_next;
            r_irq   <= w_irq_next;
        end
    end

    assign o_inst_addr   = r_pc;
    assign o_if_id_inst  = r_inst;
    assign o_if_id_pc4   = r_pc4;
    assign o_if_id_valid = r_valid;
`ifdef IF_IRQ_EN
    assign o_if_id_irq   = r_irq;
`else
    assign o_if_id_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle-level reference model plus literal spot checks.
// Interrupt expectations follow IF_IRQ_EN, matching however the DUT is built.
module tb_if_stage;

`ifdef IF_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic        clk, reset, stall, redir_valid, exc, irq;
    logic [31:0] redir_target, inst_addr, inst_data, if_id_inst, if_id_pc4;
    logic        if_id_valid, if_id_irq;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Model state: what the architectural fetch state must be after each edge.
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_irq;

    if_stage dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_stall        (stall),
        .i_redir_valid  (redir_valid),
        .i_redir_target (redir_target),
        .i_exc          (exc),
        .i_irq          (irq),
        .o_inst_addr    (inst_addr),
        .i_inst_data    (inst_data),
        .o_if_id_inst   (if_id_inst),
        .o_if_id_pc4    (if_id_pc4),
        .o_if_id_valid  (if_id_valid),
        .o_if_id_irq    (if_id_irq)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] next_seq(input logic [31:0] p);
        return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    assign inst_data = rom(inst_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 32'h8000_0000; m_inst <= 0; m_pc4 <= 0; m_valid <= 0; m_irq <= 0;
        end else if (exc) begin
            m_pc <= 32'h8000_0008; m_inst <= 0; m_valid <= 0; m_irq <= 0;
        end else if (redir_valid) begin
            m_pc <= redir_target & (m_pc[31] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
            m_inst <= 0; m_valid <= 0; m_irq <= 0;
        end else if (IrqEn && irq && !m_pc[31] && !stall) begin
            m_pc <= 32'h8000_0004; m_inst <= 0; m_valid <= 0; m_irq <= 1;
            m_pc4 <= next_seq(m_pc);
        end else if (!stall) begin
            m_pc <= next_seq(m_pc); m_inst <= rom(m_pc); m_pc4 <= next_seq(m_pc);
            m_valid <= 1; m_irq <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model addr", inst_addr, m_pc);
            chk("model valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("model irq", {31'd0, if_id_irq}, {31'd0, m_irq});
            if (m_valid) chk("model inst", if_id_inst, m_inst);
            if (m_valid || m_irq) chk("model pc4", if_id_pc4, m_pc4);
        end
    end

    task automatic cyc(input logic st, input logic rv, input logic [31:0] rt,
                       input logic ex, input logic iq);
        stall = st; redir_valid = rv; redir_target = rt; exc = ex; irq = iq;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic free();
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic [31:0] t);
        cyc(1'b0, 1'b1, t, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " addr"}, inst_addr, 32'h8000_0000);
        chk({tag, " inst"}, if_id_inst, 32'd0);
        chk({tag, " pc4"}, if_id_pc4, 32'd0);
        chk({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, " irq"}, {31'd0, if_id_irq}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 0; redir_valid = 0; redir_target = 0; exc = 0; irq = 0;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        chk_reset_state("reset");
        reset = 1'b0;
        chk("first addr", inst_addr, 32'h8000_0000);

        free();
        chk("run1 addr", inst_addr, 32'h8000_0004);
        chk("run1 pc4", if_id_pc4, 32'h8000_0004);
        chk("run1 inst", if_id_inst, 32'h0000_7FFF ^ 32'h1357_9BDF);
        free();
        chk("run2 addr", inst_addr, 32'h8000_0008);
        free();
        chk("run3 addr", inst_addr, 32'h8000_000C);
        chk("run3 pc4", if_id_pc4, 32'h8000_000C);
        chk("run3 valid", {31'd0, if_id_valid}, 32'd1);

        redir(32'h0000_000C);
        chk("to user addr", inst_addr, 32'h0000_000C);
        free();
        chk("pre-stall addr", inst_addr, 32'h0000_0010);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            chk("stall addr", inst_addr, 32'h0000_0010);
            chk("stall pc4", if_id_pc4, 32'h0000_0010);
            chk("stall valid", {31'd0, if_id_valid}, 32'd1);
        end
        free();
        chk("resume addr", inst_addr, 32'h0000_0014);
        chk("resume pc4", if_id_pc4, 32'h0000_0014);

        redir(32'h0000_0020);
        redir(32'h8000_0040);
        chk("strip k addr", inst_addr, 32'h0000_0040);
        chk("strip k valid", {31'd0, if_id_valid}, 32'd0);
        free();
        chk("after redir valid", {31'd0, if_id_valid}, 32'd1);

        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("exc addr", inst_addr, 32'h8000_0008);
        redir(32'h8000_0230);
        chk("kernel redir", inst_addr, 32'h8000_0230);
        redir(32'h0000_0050);
        chk("k to u redir", inst_addr, 32'h0000_0050);
        free();
        free();
        chk("pre-irq addr", inst_addr, 32'h0000_0058);

        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        if (IrqEn) begin
            chk("irq addr", inst_addr, 32'h8000_0004);
            chk("irq flag", {31'd0, if_id_irq}, 32'd1);
            chk("irq pc4", if_id_pc4, 32'h0000_005C);
        end else begin
            chk("irq off addr", inst_addr, 32'h0000_005C);
            chk("irq off flag", {31'd0, if_id_irq}, 32'd0);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("irq held flag", {31'd0, if_id_irq}, 32'd0);
        chk("irq held addr", inst_addr, IrqEn ? 32'h8000_0008 : 32'h0000_0060);

        cyc(1'b0, 1'b1, 32'h0000_0060, 1'b0, 1'b1);
        chk("irq+redir addr", inst_addr, 32'h0000_0060);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("irq+stall addr", inst_addr, 32'h0000_0060);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("deferred irq addr", inst_addr, IrqEn ? 32'h8000_0004 : 32'h0000_0064);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("irq stall hold", {31'd0, if_id_irq}, {31'd0, IrqEn});
        free();
        chk("irq one shot", {31'd0, if_id_irq}, 32'd0);

        redir(32'h0000_0100);
        chk("pc 100", inst_addr, 32'h0000_0100);
        cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
        chk("exc prio addr", inst_addr, 32'h8000_0008);
        chk("exc prio valid", {31'd0, if_id_valid}, 32'd0);

        redir(32'h7FFF_FFFC);
        free();
        chk("user wrap addr", inst_addr, 32'h0000_0000);
        chk("user wrap pc4", if_id_pc4, 32'h0000_0000);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        redir(32'hFFFF_FFFC);
        free();
        chk("kernel wrap addr", inst_addr, 32'h8000_0000);

        stall = 1'b1;
        #2 reset = 1'b1;
        #1 chk_reset_state("reset mid-stall");
        @(negedge clk); #1;
        reset = 1'b0;
        free();
        chk("post-reset addr", inst_addr, 32'h8000_0004);
        chk("post-reset valid", {31'd0, if_id_valid}, 32'd1);

        redir_valid = 1'b1; redir_target = 32'h0000_0300;
        #2 reset = 1'b1;
        #1 chk_reset_state("reset mid-redir");
        @(negedge clk); #1;
        redir_valid = 1'b0;
        reset = 1'b0;
        free();
        chk("post-reset2 addr", inst_addr, 32'h8000_0004);
        chk("post-reset2 pc4", if_id_pc4, 32'h8000_0004);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_VEC, default 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL provide parameter IRQ_VEC, default 32'h8000_0004, interrupt entry PC.
REQ-003 SHALL provide parameter EXC_VEC, default 32'h8000_0008, exception entry PC.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 stall  input  1  hold PC and IF/ID register (load-use hazard).
REQ-007 redir_valid  input  1  taken branch/jump/jr from a later stage.
REQ-008 redir_target  input  32  redirect destination PC.
REQ-009 exc  input  1  undefined-instruction exception from decode.
REQ-010 irq  input  1  level timer/peripheral interrupt request.
REQ-011 inst_addr  output  32  current PC, drives instruction ROM address.
REQ-012 inst_data  input  32  instruction word returned combinationally by ROM.
REQ-013 if_id_inst  output  32  registered instruction to decode.
REQ-014 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-015 if_id_valid  output  1  registered slot holds a real instruction.
REQ-016 if_id_irq  output  1  registered flag: slot is an interrupt bubble; decode writes if_id_pc4 to $k0.

Function
REQ-017 inst_addr SHALL equal the PC register; ROM read is zero-latency, IF/ID captures inst_data on the same edge the PC advances.
REQ-018 Sequential PC+4 SHALL add on bits [30:0] only; bit 31 (kernel mode) SHALL be preserved, wrapping 0x7FFF_FFFC to 0x0000_0000.
REQ-019 Next-PC priority per edge SHALL be: exc > redir_valid > irq-take > stall > PC+4.
REQ-020 exc SHALL load PC=EXC_VEC and flush IF/ID (inst=0, valid=0, irq=0), ignoring stall.
REQ-021 redir_valid SHALL load PC={PC[31] & redir_target[31], redir_target[30:0]} and flush IF/ID, ignoring stall; user code cannot enter kernel mode via redirect.
REQ-022 irq-take SHALL occur when irq=1, PC[31]=0, stall=0, no exc/redir; PC loads IRQ_VEC; IF/ID gets inst=0, valid=0, irq=1, pc4=PC+4 (instruction at PC not executed, replayed on return).
REQ-023 irq with PC[31]=1 SHALL be ignored; irq coincident with redirect SHALL be deferred to the next eligible cycle.
REQ-024 stall (with no exc/redir) SHALL hold PC and all IF/ID outputs unchanged.
REQ-025 Otherwise IF/ID SHALL load inst=inst_data, pc4=PC+4, valid=1, irq=0, and PC SHALL load PC+4.
REQ-026 if_id_irq SHALL be high for exactly one cycle per taken interrupt unless held by a subsequent stall.

Reset
REQ-027 On reset assertion, asynchronously: PC=RESET_VEC, if_id_inst=0, if_id_pc4=0, if_id_valid=0, if_id_irq=0.
REQ-028 First instruction captured SHALL be ROM word at RESET_VEC on the first edge after reset release; reset mid-redirect or mid-stall SHALL discard that pending action.

Configuration
REQ-029 With macro IF_IRQ_EN defined, interrupt logic per REQ-022/023/026 SHALL be present.
REQ-030 Without IF_IRQ_EN, irq SHALL be ignored, if_id_irq SHALL be constant 0, and IRQ_VEC unused.

Verification
REQ-031 Reset then 4 free-run cycles -> inst_addr 0x80000000,04,08,0C; if_id_pc4 0x80000004..0x8000000C, valid=1.
REQ-032 stall=1 for 2 cycles at PC 0x00000010 -> inst_addr and IF/ID outputs frozen; resume at 0x00000014.
REQ-033 redir_valid=1, target 0x80000040, PC 0x00000020 -> next PC 0x00000040 (bit 31 stripped), if_id_valid=0 one cycle.
REQ-034 Kernel PC 0x80000230, redirect to 0x00000050 -> next PC 0x00000050 (user mode).
REQ-035 IF_IRQ_EN, irq=1 at user PC 0x00000058 -> PC 0x80000004, if_id_irq=1, if_id_pc4=0x0000005C; irq held in kernel -> no re-entry.
REQ-036 exc and redir_valid and stall same cycle at PC 0x00000100 -> PC 0x80000008, if_id_valid=0.
